mod_147_3_7_hb_gen: RTL and testbench

//  - Synthesizable heartbeat generator for the Clause 147.3.7 heartbeat function.
//  - Implements both hb_timer (nominal 50 ms) and hb_send_timer (nominal 2 us) as cycle counters.
//  - Drives the heartbeat-request state machine that the PCS TX path consumes.
//  - Same *_done / *_not_done semantics as the simulation-only timer model.
//  - Sits between PHY control (hb_enable) and the PCS transmit stage (hb_send).

---
 rtl/mod_147_3_7_hb_gen.sv | 142 ++++++++++++++
 tb/tb_mod_147_3_7_hb_gen.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/mod_147_3_7_hb_gen.sv
// Heartbeat generator: hb_timer / hb_send_timer cycle counters and heartbeat-request FSM.
// Optional macro HB_COUNT_EN adds a saturating 16-bit count of completed heartbeats (hb_count).
//
// state    | meaning
// DISABLED | heartbeat function off, counters held at zero
// WAIT_HB  | hb_timer counting idle cycles; traffic restarts it
// SEND_HB  | heartbeat window open, hb_send_timer counting
module mod_147_3_7_hb_gen #(
  parameter int HB_CYCLES      = 1250000,
  parameter int HB_SEND_CYCLES = 50,
  parameter int CNT_W          = 21
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        hb_enable,
  input  logic        tx_active,
  output logic        hb_send,
  output logic        hb_timer_done,
  output logic        hb_timer_not_done,
  output logic        hb_send_timer_done,
  output logic        hb_send_timer_not_done
`ifdef HB_COUNT_EN
  ,
  output logic [15:0] hb_count
`endif
);

  typedef enum logic [1:0] {
    DISABLED = 2'd0,
    WAIT_HB  = 2'd1,
    SEND_HB  = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] HB_LAST   = CNT_W'(HB_CYCLES - 1);
  localparam logic [CNT_W-1:0] SEND_LAST = CNT_W'(HB_SEND_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  state_t           state, state_nxt;
  logic [CNT_W-1:0] hb_cnt, hb_cnt_nxt;
  logic [CNT_W-1:0] send_cnt, send_cnt_nxt;
  logic             send_nxt;
  logic             timer_done_nxt;
  logic             timer_not_done_nxt;
  logic             send_done_nxt;
  logic             send_not_done_nxt;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state                  <= DISABLED;
      hb_cnt                 <= '0;
      send_cnt               <= '0;
      hb_send                <= 1'b0;
      hb_timer_done          <= 1'b0;
      hb_timer_not_done      <= 1'b0;
      hb_send_timer_done     <= 1'b0;
      hb_send_timer_not_done <= 1'b0;
    end else begin
      state                  <= state_nxt;
      hb_cnt                 <= hb_cnt_nxt;
      send_cnt               <= send_cnt_nxt;
      hb_send                <= send_nxt;
      hb_timer_done          <= timer_done_nxt;
      hb_timer_not_done      <= timer_not_done_nxt;
      hb_send_timer_done     <= send_done_nxt;
      hb_send_timer_not_done <= send_not_done_nxt;
    end
  end

  // Output flops are loaded from the next-state view so every output is a register.
  always_comb begin
    state_nxt          = state;
    hb_cnt_nxt         = hb_cnt;
    send_cnt_nxt       = send_cnt;
    send_nxt           = 1'b0;
    timer_done_nxt     = 1'b0;
    timer_not_done_nxt = 1'b0;
    send_done_nxt      = 1'b0;
    send_not_done_nxt  = 1'b0;

    if (!hb_enable) begin
      state_nxt    = DISABLED;
      hb_cnt_nxt   = '0;
      send_cnt_nxt = '0;
    end else begin
      case (state)
        DISABLED: begin
          state_nxt          = WAIT_HB;
          hb_cnt_nxt         = '0;
          send_cnt_nxt       = '0;
          timer_not_done_nxt = 1'b1;
        end
        WAIT_HB: begin
          timer_not_done_nxt = 1'b1;
          if (tx_active) begin
            hb_cnt_nxt = '0;
          end else if (hb_cnt == HB_LAST) begin
            state_nxt          = SEND_HB;
            hb_cnt_nxt         = '0;
            send_cnt_nxt       = '0;
            send_nxt           = 1'b1;
            timer_done_nxt     = 1'b1;
            timer_not_done_nxt = 1'b0;
            send_not_done_nxt  = 1'b1;
          end else begin
            hb_cnt_nxt = hb_cnt + CNT_ONE;
          end
        end
        SEND_HB: begin
          // tx_active is deliberately ignored: a started heartbeat always completes.
          if (send_cnt == SEND_LAST) begin
            state_nxt          = WAIT_HB;
            hb_cnt_nxt         = '0;
            send_cnt_nxt       = '0;
            send_done_nxt      = 1'b1;
            timer_not_done_nxt = 1'b1;
          end else begin
            send_cnt_nxt      = send_cnt + CNT_ONE;
            send_nxt          = 1'b1;
            send_not_done_nxt = 1'b1;
          end
        end
        default: begin
          state_nxt    = DISABLED;
          hb_cnt_nxt   = '0;
          send_cnt_nxt = '0;
        end
      endcase
    end
  end

`ifdef HB_COUNT_EN
  // Survives hb_enable=0; only reset clears it.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      hb_count <= 16'h0000;
    end else if (send_done_nxt && (hb_count != 16'hFFFF)) begin
      hb_count <= hb_count + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_mod_147_3_7_hb_gen.sv
// Scoreboard bench for mod_147_3_7_hb_gen (HB_CYCLES=10, HB_SEND_CYCLES=3).
// Expected done pulses are queued with their cycle numbers; a monitor pops and checks them.
module tb_mod_147_3_7_hb_gen;
  localparam int HB  = 10;
  localparam int SND = 3;

  logic clk = 1'b0;
  logic reset_n;
  logic hb_enable;
  logic tx_active;
  logic hb_send;
  logic hb_timer_done;
  logic hb_timer_not_done;
  logic hb_send_timer_done;
  logic hb_send_timer_not_done;
`ifdef HB_COUNT_EN
  logic [15:0] hb_count;
`endif

  int cyc     = 0;
  int vectors = 0;
  int errs    = 0;

  typedef struct {
    int kind;
    int at;
  } ev_t;
  ev_t exp_q[$];

  mod_147_3_7_hb_gen #(
    .HB_CYCLES(HB),
    .HB_SEND_CYCLES(SND),
    .CNT_W(21)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .hb_enable(hb_enable),
    .tx_active(tx_active),
    .hb_send(hb_send),
    .hb_timer_done(hb_timer_done),
    .hb_timer_not_done(hb_timer_not_done),
    .hb_send_timer_done(hb_send_timer_done),
    .hb_send_timer_not_done(hb_send_timer_not_done)
`ifdef HB_COUNT_EN
    ,
    .hb_count(hb_count)
`endif
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    vectors++;
    if (act !== req) begin
      errs++;
      $display("FAIL %s: got %0h, want %0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic push(input int kind, input int at);
    exp_q.push_back('{kind: kind, at: at});
  endtask

  task automatic wait_to(input int k);
    while (cyc < k) begin
      @(posedge clk);
      #1;
    end
  endtask

  // kind 0 = hb_timer_done, kind 1 = hb_send_timer_done
  task automatic see(input int kind);
    ev_t e;
    if (exp_q.size() == 0) begin
      vectors++;
      errs++;
      $display("FAIL unexpected_pulse: got kind %0d at cycle %0d, want no pulse", kind, cyc);
    end else begin
      e = exp_q.pop_front();
      check("pulse_kind", kind, e.kind);
      check("pulse_cycle", cyc, e.at);
    end
    if (kind == 0)
      check("levels_at_timer_done", {hb_send, hb_timer_not_done, hb_send_timer_not_done}, 3'b101);
    else
      check("levels_at_send_done", {hb_send, hb_timer_not_done, hb_send_timer_not_done}, 3'b010);
  endtask

  always @(negedge clk) begin
    if (reset_n === 1'b1) begin
      if (hb_timer_done) see(0);
      if (hb_send_timer_done) see(1);
    end
  end

  initial begin
    int e, w, w2, w3, w4, e2, w5;
    reset_n   = 1'b0;
    hb_enable = 1'b0;
    tx_active = 1'b0;
    @(posedge clk);
    #1;
    check("reset_outputs", {hb_send, hb_timer_done, hb_timer_not_done,
                            hb_send_timer_done, hb_send_timer_not_done}, 5'b0);
`ifdef HB_COUNT_EN
    check("reset_count", hb_count, 16'h0);
`endif
    wait_to(3);
    reset_n = 1'b1;
    wait_to(23);
    check("disabled_outputs", {hb_send, hb_timer_done, hb_timer_not_done,
                               hb_send_timer_done, hb_send_timer_not_done}, 5'b0);

    // Periodic heartbeat, idle line
    hb_enable = 1'b1;
    e = cyc + 1;
    for (int i = 0; i < 3; i++) begin
      push(0, e + 10 + 13 * i);
      push(1, e + 13 + 13 * i);
    end
    wait_to(e);
    check("enable_not_done", hb_timer_not_done, 1'b1);
    wait_to(e + 9);
    check("send_before_expiry", hb_send, 1'b0);
    wait_to(e + 10);
    check("send_rise", hb_send, 1'b1);
    wait_to(e + 12);
    check("send_last_cycle", hb_send, 1'b1);
    wait_to(e + 13);
    check("send_fall", hb_send, 1'b0);
    w = e + 39;
    wait_to(w);
`ifdef HB_COUNT_EN
    check("count_three", hb_count, 16'd3);
`endif

    // Traffic on cycle 8 of WAIT_HB defers the heartbeat
    wait_to(w + 7);
    tx_active = 1'b1;
    wait_to(w + 10);
    tx_active = 1'b0;
    check("deferred_not_done", hb_timer_not_done, 1'b1);
    push(0, w + 20);
    push(1, w + 23);
    w2 = w + 23;

    // Traffic exactly at the expiry edge
    wait_to(w2 + 9);
    tx_active = 1'b1;
    wait_to(w2 + 10);
    tx_active = 1'b0;
    check("expiry_tx_no_send", {hb_send, hb_timer_not_done}, 2'b01);
    push(0, w2 + 20);
    push(1, w2 + 23);
    w3 = w2 + 23;

    // Traffic during SEND_HB does not shorten the window
    push(0, w3 + 10);
    push(1, w3 + 13);
    wait_to(w3 + 10);
    tx_active = 1'b1;
    wait_to(w3 + 11);
    check("send_with_tx_1", hb_send, 1'b1);
    wait_to(w3 + 12);
    check("send_with_tx_2", hb_send, 1'b1);
    wait_to(w3 + 13);
    tx_active = 1'b0;
    push(0, w3 + 23);
    push(1, w3 + 26);
    w4 = w3 + 26;

    // Disable on the 2nd SEND_HB cycle: no send-done pulse
    push(0, w4 + 10);
    wait_to(w4 + 11);
    check("send_before_disable", hb_send, 1'b1);
    hb_enable = 1'b0;
    wait_to(w4 + 12);
    check("disable_clears", {hb_send, hb_timer_not_done, hb_send_timer_not_done}, 3'b000);
    wait_to(w4 + 15);
    hb_enable = 1'b1;
    e2 = cyc + 1;
    push(0, e2 + 10);
    push(1, e2 + 13);
    wait_to(e2 + 9);
    check("reenable_before", hb_send, 1'b0);
    wait_to(e2 + 10);
    check("reenable_rise", hb_send, 1'b1);
    w5 = e2 + 13;
    wait_to(w5);

    push(0, w5 + 10);
    push(1, w5 + 13);
`ifdef HB_COUNT_EN
    check("count_eight", hb_count, 16'd8);
    wait_to(w5 + 2);
    force dut.hb_count = 16'hFFFF;
    #1;
    release dut.hb_count;
    wait_to(w5 + 14);
    check("count_saturated", hb_count, 16'hFFFF);
`endif

    // Asynchronous reset in the middle of SEND_HB
    push(0, w5 + 23);
    wait_to(w5 + 24);
    check("send_before_reset", hb_send, 1'b1);
    reset_n = 1'b0;
    #1;
    check("async_reset_send", hb_send, 1'b0);
`ifdef HB_COUNT_EN
    check("async_reset_count", hb_count, 16'h0);
`endif
    wait_to(w5 + 28);
    reset_n = 1'b1;
    wait_to(w5 + 30);
    check("queue_drained", exp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end
endmodule
